// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing multiply/count slice.
// Optional build macro: SC_BIPOLAR_EN (XNOR combine instead of AND).
package sc_pkg;

   localparam int unsigned SC_N  = 32;
   localparam int unsigned SC_CW = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } sc_state_e;

   // Width needed to hold the value n (a full-ones count).
   function automatic int unsigned sc_cw(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sc_popcnt_acc.sv
// Serial combine-and-count engine: one bit pair per step.
// Optional build macro: SC_BIPOLAR_EN (XNOR combine instead of AND).
// acc presents the running total including the bit pair of the current
// step, so the top can latch the final count on the last step's edge.
module sc_popcnt_acc
   import sc_pkg::*;
#(
   parameter int unsigned N  = SC_N,
   parameter int unsigned CW = sc_cw(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          step,
   input  logic          a_bit,
   input  logic          b_bit,
   output logic [CW-1:0] acc,
   output logic          last
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic [CW-1:0] acc_q, acc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          hit;

   // Combine the current bit pair.
   always_comb begin
`ifdef SC_BIPOLAR_EN
      hit = ~(a_bit ^ b_bit);
`else
      hit = a_bit & b_bit;
`endif
   end

   // Running count including this step's bit; last marks the final bit index.
   always_comb begin
      acc  = acc_q + CW'(hit & step);
      last = (idx_q == IW'(N - 1));
   end

   // Next-state for accumulator and index; clear wins over step.
   always_comb begin
      acc_d = acc_q;
      idx_d = idx_q;
      if (clr) begin
         acc_d = '0;
         idx_d = '0;
      end else if (step) begin
         acc_d = acc;
         idx_d = last ? '0 : idx_q + 1'b1;
      end
   end

   // Accumulator and index registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
         idx_q <= '0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/sc_mul_count.sv
// Captures two SC bitstreams, combines them bitwise and counts the ones
// serially, returning a binary result N+2 cycles after the strobe.
// Optional build macro: SC_BIPOLAR_EN (XNOR combine instead of AND).
module sc_mul_count
   import sc_pkg::*;
#(
   parameter int unsigned N  = SC_N,
   parameter int unsigned CW = sc_cw(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          in_valid,
   input  logic [N-1:0]  seq_a,
   input  logic [N-1:0]  seq_b,
   output logic          busy,
   output logic          out_valid,
   output logic [CW-1:0] result,
   output logic          drop
);

   sc_state_e     state_q, state_d;
   logic [N-1:0]  a_sr_q, a_sr_d;
   logic [N-1:0]  b_sr_q, b_sr_d;
   logic [CW-1:0] result_q, result_d;
   logic          drop_q, drop_d;

   logic [CW-1:0] acc;
   logic          last;
   logic          clr;
   logic          step;

   // Counter runs only in RUN; anything else (including en low) holds it clear.
   always_comb begin
      step = en & (state_q == RUN);
      clr  = ~step;
   end

   sc_popcnt_acc #(
      .N  (N),
      .CW (CW)
   ) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .step  (step),
      .a_bit (a_sr_q[0]),
      .b_bit (b_sr_q[0]),
      .acc   (acc),
      .last  (last)
   );

   // Next-state and datapath decode; en low clears everything synchronously.
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      result_d = result_q;
      drop_d   = 1'b0;
      if (!en) begin
         state_d  = IDLE;
         a_sr_d   = '0;
         b_sr_d   = '0;
         result_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) state_d = ARM;
            end
            ARM: begin
               a_sr_d  = seq_a;
               b_sr_d  = seq_b;
               drop_d  = in_valid;
               state_d = RUN;
            end
            RUN: begin
               a_sr_d = a_sr_q >> 1;
               b_sr_d = b_sr_q >> 1;
               drop_d = in_valid;
               if (last) begin
                  result_d = acc;
                  state_d  = DONE;
               end
            end
            DONE: begin
               state_d = in_valid ? ARM : IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, shift and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         result_q <= '0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         result_q <= result_d;
         drop_q   <= drop_d;
      end
   end

   // Status outputs decoded from the state register.
   always_comb begin
      busy      = (state_q == ARM) || (state_q == RUN);
      out_valid = (state_q == DONE);
      result    = result_q;
      drop      = drop_q;
   end

endmodule

// File: tb/tb_sc_mul_count.sv
// Self-checking bench for sc_mul_count: job-level reference model checked
// every cycle, plus directed jobs with hand-computed results.
// Optional build macro: SC_BIPOLAR_EN (XNOR combine instead of AND).
module tb_sc_mul_count;

   localparam int unsigned N  = 32;
   localparam int unsigned CW = 6;
   localparam int LAT = N + 2;

`ifdef SC_BIPOLAR_EN
   localparam int R_AA = 32;
`else
   localparam int R_AA = 16;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          in_valid = 1'b0;
   logic [N-1:0]  seq_a = '0;
   logic [N-1:0]  seq_b = '0;
   logic          busy;
   logic          out_valid;
   logic [CW-1:0] result;
   logic          drop;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sc_mul_count #(.N(N), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .seq_a     (seq_a),
      .seq_b     (seq_b),
      .busy      (busy),
      .out_valid (out_valid),
      .result    (result),
      .drop      (drop)
   );

   function automatic int comb_count(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef SC_BIPOLAR_EN
      return $countones(~(a ^ b));
`else
      return $countones(a & b);
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a job accepted in cycle t is busy t+1..t+N+1, captures
   // its operands from cycle t+1, and reports in cycle t+N+2.
   int ph = 0;
   int m_val = 0;
   int m_res = 0;
   bit m_drop = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst || !en) begin
         ph = 0; m_val = 0; m_res = 0; m_drop = 0;
      end else begin
         m_drop = in_valid && (ph >= 1) && (ph <= LAT - 1);
         if (ph == 0 || ph == LAT) begin
            ph = in_valid ? 1 : 0;
         end else if (ph == 1) begin
            m_val = comb_count(seq_a, seq_b);
            ph = 2;
         end else begin
            ph++;
            if (ph == LAT) m_res = m_val;
         end
      end
      #1;
      check("model_busy", int'(busy), int'(ph >= 1 && ph <= LAT - 1));
      check("model_out_valid", int'(out_valid), int'(ph == LAT));
      check("model_drop", int'(drop), int'(m_drop));
      check("model_result", int'(result), m_res);
   end

   int t_strobe;

   task automatic strobe(input logic [N-1:0] a, input logic [N-1:0] b);
      @(negedge clk);
      seq_a = a; seq_b = b; in_valid = 1'b1;
      t_strobe = cyc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int at, output bit ok);
      ok = 0; at = -1;
      for (int i = 0; i < 3 * LAT; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            at = cyc; ok = 1;
            return;
         end
      end
   endtask

   task automatic job(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                      input int exp_res);
      int at; bit ok; int t0;
      strobe(a, b);
      t0 = t_strobe;
      wait_done(at, ok);
      check({name, "_timeout"}, int'(ok), 1);
      check({name, "_latency"}, at - t0, LAT);
      check({name, "_result"}, int'(result), exp_res);
   endtask

   initial begin
      int at; bit ok; int t0; int ov_seen;
      #2;
      check("reset_busy", int'(busy), 0);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_result", int'(result), 0);
      check("reset_drop", int'(drop), 0);
      #20;
      rst = 1'b1;
      @(negedge clk);
      en = 1'b1;

      // Half of B set, all of A.
      strobe(32'hFFFF_FFFF, 32'h0000_FFFF);
      t0 = t_strobe;
      check("t1_busy_arm", int'(busy), 1);
      wait_done(at, ok);
      check("t1_timeout", int'(ok), 1);
      check("t1_latency", at - t0, LAT);
      check("t1_result", int'(result), 16);
      check("t1_busy_done", int'(busy), 0);

      job("t2_full", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
      job("t2_zero", 32'h0000_0000, 32'hFFFF_FFFF, 0);
      job("t3_alt", 32'hAAAA_AAAA, 32'h5555_5555, 0);
      job("t3_same", 32'hAAAA_AAAA, 32'hAAAA_AAAA, R_AA);

      // Strobe mid-job is dropped; strobe in DONE starts a back-to-back job.
      strobe(32'hFFFF_FFFF, 32'h0000_FFFF);
      t0 = t_strobe;
      repeat (9) @(negedge clk);
      seq_a = 32'h1234_5678; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("t4_drop", int'(drop), 1);
      wait_done(at, ok);
      check("t4_first_latency", at - t0, LAT);
      check("t4_first_result", int'(result), 16);
      seq_a = 32'hFFFF_FFFF; seq_b = 32'hFFFF_FFFF; in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_done(at, ok);
      check("t4_second_latency", at - t0, 2 * LAT);
      check("t4_second_result", int'(result), 32);

      // en low mid-run aborts the job and clears result.
      strobe(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (19) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      check("t5_en_busy", int'(busy), 0);
      check("t5_en_result", int'(result), 0);
      ov_seen = 0;
      for (int i = 0; i < LAT + 4; i++) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
      end
      check("t5_en_no_out_valid", ov_seen, 0);

      // Asynchronous reset mid-run.
      job("t5_pre_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
      strobe(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("t5_rst_busy", int'(busy), 0);
      check("t5_rst_result", int'(result), 0);
      check("t5_rst_out_valid", int'(out_valid), 0);
      @(negedge clk);
      rst = 1'b1;

      // Operand change after the capture edge has no effect.
      strobe(32'hFFFF_FFFF, 32'h0F0F_0F0F);
      t0 = t_strobe;
      @(negedge clk);
      seq_a = '0;
      wait_done(at, ok);
      check("t6_latency", at - t0, LAT);
      check("t6_result", int'(result), 16);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         en       = ($urandom_range(0, 49) != 0);
         in_valid = ($urandom_range(0, 9) == 0);
         seq_a    = $urandom;
         seq_b    = $urandom;
      end
      @(negedge clk);
      en = 1'b1; in_valid = 1'b0;
      repeat (LAT + 4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
